// File: rtl/sobel_ctrl_pkg.sv
// Shared types and default parameters for the Sobel threshold controller.
package sobel_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        IN_FRAME = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    localparam int TH_INIT_D = 64;
    localparam int TH_STEP_D = 4;
    localparam int TH_MIN_D  = 8;
    localparam int TH_MAX_D  = 248;
    localparam int CNT_W_D   = 20;

endpackage

// File: rtl/sobel_edge_counter.sv
// Saturating edge-pixel counter with enable and synchronous clear.
module sobel_edge_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/sobel_threshold_ctrl.sv
// Frame-synchronous threshold controller for a Sobel edge detector:
// counts edge pixels per frame and applies host config or auto-adjust.
module sobel_threshold_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int TH_INIT = TH_INIT_D,
    parameter int TH_STEP = TH_STEP_D,
    parameter int TH_MIN  = TH_MIN_D,
    parameter int TH_MAX  = TH_MAX_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             post_frame_vsync,
    input  logic             post_frame_href,
    input  logic             post_frame_clken,
    input  logic             post_img_Bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_mode,
    input  logic [7:0]       cfg_threshold,
    input  logic [CNT_W-1:0] cfg_target_lo,
    input  logic [CNT_W-1:0] cfg_target_hi,
    output logic [7:0]       Sobel_Threshold,
    output logic [CNT_W-1:0] frame_edge_count,
    output logic             frame_count_valid,
    output logic             auto_mode
);

    state_e           state_q, state_d;
    logic             vs_q, pvs_q;
    logic             sof, eof, xfer, apply;
    logic [7:0]       th_q, th_d;
    logic             auto_q, auto_d;
    logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             pend_q, pend_d;
    logic [7:0]       sh_th_q;
    logic             sh_mode_q;
    logic [CNT_W-1:0] sh_lo_q, sh_hi_q;
    logic [CNT_W-1:0] cnt, fec_q;
    logic             fcv_q;
    logic [8:0]       th_up, th_dn;

    assign sof   = per_frame_vsync & ~vs_q;
    assign eof   = ~post_frame_vsync & pvs_q;
    assign xfer  = cfg_valid & ~pend_q;
    assign apply = pend_q & (state_q == WAIT_SOF || state_q == UPDATE);
    assign th_up = {1'b0, th_q} + 9'(TH_STEP);
    assign th_dn = {1'b0, th_q} - 9'(TH_STEP);

    sobel_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state_q == IN_FRAME) & post_frame_href &
                post_frame_clken & post_img_Bit),
        .clr   (state_q == UPDATE),
        .count (cnt)
    );

    always_comb begin
        state_d = state_q;
        th_d    = th_q;
        auto_d  = auto_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pend_d  = pend_q | xfer;
        unique case (state_q)
            WAIT_SOF: if (sof) state_d = IN_FRAME;
            IN_FRAME: if (eof) state_d = UPDATE;
            UPDATE:   state_d = sof ? IN_FRAME : WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
        if (apply) begin
            th_d   = sh_th_q;
            auto_d = sh_mode_q;
            lo_d   = sh_lo_q;
            hi_d   = sh_hi_q;
            pend_d = 1'b0;
        end else if (state_q == UPDATE && auto_q) begin
            // 9-bit sums so the step can never wrap past 0 or 255
            if (cnt > hi_q) begin
                th_d = (th_up > 9'(TH_MAX)) ? 8'(TH_MAX) : th_up[7:0];
            end else if (cnt < lo_q) begin
                th_d = (th_dn[8] || th_dn < 9'(TH_MIN)) ? 8'(TH_MIN)
                                                        : th_dn[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SOF;
            vs_q    <= 1'b1;
            pvs_q   <= 1'b1;
            th_q    <= 8'(TH_INIT);
            auto_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            pend_q  <= 1'b0;
            fec_q   <= '0;
            fcv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= per_frame_vsync;
            pvs_q   <= post_frame_vsync;
            th_q    <= th_d;
            auto_q  <= auto_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pend_q  <= pend_d;
            fcv_q   <= (state_q == UPDATE);
            if (state_q == UPDATE) fec_q <= cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_th_q   <= '0;
            sh_mode_q <= 1'b0;
            sh_lo_q   <= '0;
            sh_hi_q   <= '0;
        end else if (xfer) begin
            sh_th_q   <= cfg_threshold;
            sh_mode_q <= cfg_mode;
            sh_lo_q   <= cfg_target_lo;
            sh_hi_q   <= cfg_target_hi;
        end
    end

    assign cfg_ready         = ~pend_q;
    assign Sobel_Threshold   = th_q;
    assign frame_edge_count  = fec_q;
    assign frame_count_valid = fcv_q;
    assign auto_mode         = auto_q;

endmodule

// File: tb/tb_sobel_threshold_ctrl.sv
// Directed bench for sobel_threshold_ctrl (default build plus a CNT_W=4 build).
module tb_sobel_threshold_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pvs, ppvs, href, clken, pbit;
    logic        cfg_valid, cfg_mode;
    logic [7:0]  cfg_th;
    logic [19:0] cfg_lo, cfg_hi;
    logic        cfg_ready, fcv, auto_m;
    logic [7:0]  th;
    logic [19:0] fec;
    logic        s_ready, s_fcv, s_auto;
    logic [7:0]  s_th;
    logic [3:0]  s_fec;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    sobel_threshold_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(pvs), .post_frame_vsync(ppvs),
        .post_frame_href(href), .post_frame_clken(clken),
        .post_img_Bit(pbit),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_threshold(cfg_th),
        .cfg_target_lo(cfg_lo), .cfg_target_hi(cfg_hi),
        .Sobel_Threshold(th), .frame_edge_count(fec),
        .frame_count_valid(fcv), .auto_mode(auto_m)
    );

    sobel_threshold_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(pvs), .post_frame_vsync(ppvs),
        .post_frame_href(href), .post_frame_clken(clken),
        .post_img_Bit(pbit),
        .cfg_valid(cfg_valid), .cfg_ready(s_ready),
        .cfg_mode(cfg_mode), .cfg_threshold(cfg_th),
        .cfg_target_lo(cfg_lo[3:0]), .cfg_target_hi(cfg_hi[3:0]),
        .Sobel_Threshold(s_th), .frame_edge_count(s_fec),
        .frame_count_valid(s_fcv), .auto_mode(s_auto)
    );

    always @(negedge clk) if (fcv) pulses++;

    task automatic cfg_write(input logic m, input logic [7:0] t,
                             input logic [19:0] lo, input logic [19:0] hi);
        int i;
        for (i = 0; i < 20; i++) begin
            if (cfg_ready) break;
            @(negedge clk);
        end
        n_chk++;
        if (i == 20) begin
            n_fail++;
            $display("FAIL cfg_ready_timeout: ready=%b required 1", cfg_ready);
        end
        cfg_valid = 1'b1; cfg_mode = m; cfg_th = t; cfg_lo = lo; cfg_hi = hi;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pixels(input int ne, input int nn);
        for (int i = 0; i < ne; i++) begin
            href = 1; clken = 1; pbit = 1; @(negedge clk);
        end
        for (int i = 0; i < nn; i++) begin
            href = 0; clken = 1; pbit = 1; @(negedge clk);
        end
        href = 0; clken = 0; pbit = 0;
    endtask

    task automatic frame(input int ne, input int nn);
        @(negedge clk); pvs = 1; ppvs = 1;
        @(negedge clk);
        pixels(ne, nn);
        @(negedge clk); pvs = 0; ppvs = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0; pvs = 0; ppvs = 0; href = 0; clken = 0; pbit = 0;
        cfg_valid = 0; cfg_mode = 0; cfg_th = 0; cfg_lo = 0; cfg_hi = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (th !== 8'd64) begin n_fail++;
            $display("FAIL reset_th: got %0d required 64", th); end
        n_chk++; if (auto_m !== 1'b0) begin n_fail++;
            $display("FAIL reset_auto: got %b required 0", auto_m); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b required 1", cfg_ready); end
        n_chk++; if (fec !== 20'd0) begin n_fail++;
            $display("FAIL reset_fec: got %0d required 0", fec); end
        n_chk++; if (fcv !== 1'b0) begin n_fail++;
            $display("FAIL reset_fcv: got %b required 0", fcv); end
    endtask

    task automatic test_manual_write;
        cfg_write(1'b0, 8'd100, 20'd0, 20'd0);
        n_chk++; if (cfg_ready !== 1'b0) begin n_fail++;
            $display("FAIL manual_pending: ready=%b required 0", cfg_ready); end
        @(negedge clk);
        n_chk++; if (th !== 8'd100) begin n_fail++;
            $display("FAIL manual_th: got %0d required 100", th); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++;
            $display("FAIL manual_ready: got %b required 1", cfg_ready); end
    endtask

    task automatic test_midframe_write;
        @(negedge clk); pvs = 1; ppvs = 1;
        @(negedge clk);
        cfg_write(1'b0, 8'd50, 20'd0, 20'd0);
        n_chk++; if (cfg_ready !== 1'b0) begin n_fail++;
            $display("FAIL mid_ready_low: got %b required 0", cfg_ready); end
        pixels(3, 0);
        n_chk++; if (th !== 8'd100) begin n_fail++;
            $display("FAIL mid_th_hold: got %0d required 100", th); end
        pvs = 0; ppvs = 0;
        @(negedge clk);
        n_chk++; if (th !== 8'd100) begin n_fail++;
            $display("FAIL mid_th_eof: got %0d required 100", th); end
        @(negedge clk);
        n_chk++; if (th !== 8'd50) begin n_fail++;
            $display("FAIL mid_th_update: got %0d required 50", th); end
        n_chk++; if (cfg_ready !== 1'b1) begin n_fail++;
            $display("FAIL mid_ready_high: got %b required 1", cfg_ready); end
        n_chk++; if (fec !== 20'd3) begin n_fail++;
            $display("FAIL mid_fec: got %0d required 3", fec); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_counting;
        int p0;
        p0 = pulses;
        frame(37, 5);
        n_chk++; if (fec !== 20'd37) begin n_fail++;
            $display("FAIL count_fec: got %0d required 37", fec); end
        n_chk++; if (pulses - p0 !== 1) begin n_fail++;
            $display("FAIL count_pulses: got %0d required 1", pulses - p0); end
        n_chk++; if (th !== 8'd50) begin n_fail++;
            $display("FAIL count_th_manual: got %0d required 50", th); end
    endtask

    task automatic test_saturation;
        frame(20, 0);
        n_chk++; if (s_fec !== 4'd15) begin n_fail++;
            $display("FAIL sat_fec4: got %0d required 15", s_fec); end
        n_chk++; if (fec !== 20'd20) begin n_fail++;
            $display("FAIL sat_fec20: got %0d required 20", fec); end
    endtask

    task automatic test_auto_clamp;
        cfg_write(1'b1, 8'd246, 20'd0, 20'd10);
        @(negedge clk);
        n_chk++; if (th !== 8'd246 || auto_m !== 1'b1) begin n_fail++;
            $display("FAIL auto_cfg: th=%0d auto=%b required 246/1", th, auto_m); end
        frame(500, 0);
        n_chk++; if (th !== 8'd248) begin n_fail++;
            $display("FAIL auto_hi1: got %0d required 248", th); end
        n_chk++; if (fec !== 20'd500) begin n_fail++;
            $display("FAIL auto_fec: got %0d required 500", fec); end
        frame(500, 0);
        n_chk++; if (th !== 8'd248) begin n_fail++;
            $display("FAIL auto_hi2: got %0d required 248", th); end
        cfg_write(1'b1, 8'd10, 20'd100, 20'd200);
        @(negedge clk);
        frame(0, 0);
        n_chk++; if (th !== 8'd8) begin n_fail++;
            $display("FAIL auto_lo: got %0d required 8", th); end
        frame(150, 0);
        n_chk++; if (th !== 8'd8) begin n_fail++;
            $display("FAIL auto_hold: got %0d required 8", th); end
    endtask

    task automatic test_manual_unclamped;
        cfg_write(1'b0, 8'd255, 20'd0, 20'd0);
        @(negedge clk);
        n_chk++; if (th !== 8'd255 || auto_m !== 1'b0) begin n_fail++;
            $display("FAIL manual_255: th=%0d auto=%b required 255/0", th, auto_m); end
    endtask

    task automatic test_reset_midframe;
        int p0;
        @(negedge clk); pvs = 1; ppvs = 1;
        @(negedge clk);
        pixels(3, 0);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        p0 = pulses;
        @(negedge clk);
        n_chk++; if (th !== 8'd64) begin n_fail++;
            $display("FAIL rstmid_th: got %0d required 64", th); end
        pixels(5, 0);
        @(negedge clk); pvs = 0; ppvs = 0;
        repeat (4) @(negedge clk);
        n_chk++; if (pulses != p0 || fec !== 20'd0) begin n_fail++;
            $display("FAIL rstmid_nosof: pulses=%0d fec=%0d required 0/0",
                     pulses - p0, fec); end
        frame(3, 0);
        n_chk++; if (fec !== 20'd3 || pulses - p0 != 1) begin n_fail++;
            $display("FAIL rstmid_next: fec=%0d pulses=%0d required 3/1",
                     fec, pulses - p0); end
        n_chk++; if (th !== 8'd64) begin n_fail++;
            $display("FAIL rstmid_th_after: got %0d required 64", th); end
    endtask

    initial begin
        test_reset;
        test_manual_write;
        test_midframe_write;
        test_counting;
        test_saturation;
        test_auto_clamp;
        test_manual_unclamped;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
